// File: rtl/serial_shift_right_unit.sv
// serial_shift_right_unit: multi-cycle SRL/SRA that shifts one bit per clock.
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - request, sampled only in IDLE
//   arith    - 1 = sign-fill, 0 = zero-fill (latched with start)
//   in_value - operand (latched with start)
//   shamt    - shift amount (latched with start)
//   busy     - high while shifting
//   done     - one-cycle pulse, result valid
//   result   - shifted value, held until next completion or reset
module serial_shift_right_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   in_value,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] count;
  logic               mode;
  logic               fill;

  always_comb begin
    fill = mode & sreg[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sreg   <= '0;
      count  <= '0;
      mode   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sreg  <= in_value;
            count <= shamt;
            mode  <= arith;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            sreg  <= {fill, sreg[WIDTH-1:1]};
            count <= count - 1'b1;
          end else begin
            result <= sreg;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not sampled here: one idle cycle between ops
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_right_unit.sv
module tb_serial_shift_right_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [31:0] in_value;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  serial_shift_right_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .arith    (arith),
    .in_value (in_value),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] v;
    logic [4:0]  s;
    logic        a;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Accept an op, then count edges until done. Returns result, latency in edges
  // after the accepting edge, busy cycles seen, and whether done arrived.
  task automatic run_op(input logic [31:0] v, input logic [4:0] s, input logic a,
                        output logic [31:0] r, output int lat, output int bcnt,
                        output logic seen);
    @(negedge clk);
    in_value = v; shamt = s; arith = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_value = 32'hDEAD_BEEF; shamt = 5'd3; arith = ~a;
    lat = 0; bcnt = 0; seen = 1'b0; r = '0;
    while (!seen && lat < 70) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        r = result;
      end
    end
  endtask

  task automatic count_extra_done(input int n, output int dcnt);
    dcnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
  endtask

  initial begin
    logic [31:0] r;
    int lat, bcnt, dcnt;
    logic seen;

    vecs[0] = '{32'h0000_0220, 5'd1,  1'b0, 32'h0000_0110};
    vecs[1] = '{32'h0020_0030, 5'd4,  1'b0, 32'h0002_0003};
    vecs[2] = '{32'h8000_0033, 5'd4,  1'b1, 32'hF800_0003};
    vecs[3] = '{32'h8000_0033, 5'd4,  1'b0, 32'h0800_0003};
    vecs[4] = '{32'h0000_0002, 5'd0,  1'b0, 32'h0000_0002};
    vecs[5] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[6] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[7] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
    vecs[8] = '{32'hF0F0_F0F0, 5'd8,  1'b1, 32'hFFF0_F0F0};
    vecs[9] = '{32'hF0F0_F0F0, 5'd8,  1'b0, 32'h00F0_F0F0};

    // Reset held with start asserted
    rst_n = 1'b0; start = 1'b1; arith = 1'b1; in_value = 32'hFFFF_FFFF; shamt = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   busy,   0);
    chk("reset done",   done,   0);
    chk("reset result", result, 32'h0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].v, vecs[i].s, vecs[i].a, r, lat, bcnt, seen);
      chk($sformatf("v%0d done_seen", i), seen, 1);
      chk($sformatf("v%0d result", i), r, vecs[i].exp);
      chk($sformatf("v%0d latency", i), lat, vecs[i].s + 1);
      chk($sformatf("v%0d busy_cycles", i), bcnt, vecs[i].s + 1);
      chk($sformatf("v%0d busy_at_done", i), busy, 0);
      count_extra_done(3, dcnt);
      chk($sformatf("v%0d extra_done", i), dcnt, 0);
      chk($sformatf("v%0d result_hold", i), result, vecs[i].exp);
    end

    // Start pulses and operand changes while busy are ignored
    @(negedge clk);
    in_value = 32'h0020_0030; shamt = 5'd4; arith = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; seen = 1'b0; dcnt = 0; r = '0;
    while (lat < 12) begin
      if (lat == 1) begin
        start = 1'b1; in_value = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
      end
      if (lat == 3) start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) begin
        dcnt++;
        if (!seen) begin
          seen = 1'b1;
          r = result;
          chk("busy_restart latency", lat, 5);
        end
      end
    end
    chk("busy_restart done_seen", seen, 1);
    chk("busy_restart result", r, 32'h0002_0003);
    chk("busy_restart done_pulses", dcnt, 1);

    // Start presented during the DONE cycle is ignored, accepted in next IDLE
    run_op(32'h0000_0004, 5'd2, 1'b0, r, lat, bcnt, seen);
    chk("dstart first_result", r, 32'h0000_0001);
    in_value = 32'h0000_0440; shamt = 5'd1; arith = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("dstart ignored_busy", busy, 0);
    chk("dstart ignored_done", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("dstart accepted_busy", busy, 1);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    chk("dstart done_seen", seen, 1);
    chk("dstart latency", lat, 2);
    chk("dstart result", result, 32'h0000_0220);

    // Reset mid-shift aborts with no done pulse
    @(negedge clk);
    in_value = 32'h0000_0220; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst busy",   busy,   0);
    chk("midrst done",   done,   0);
    chk("midrst result", result, 32'h0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("midrst quiet", dcnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_extra_done(10, dcnt);
    chk("midrst no_done_after_release", dcnt, 0);
    run_op(32'h8000_0033, 5'd4, 1'b1, r, lat, bcnt, seen);
    chk("midrst new_done_seen", seen, 1);
    chk("midrst new_result", r, 32'hF800_0003);
    chk("midrst new_latency", lat, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
